// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: one-hot grant decoded from the winner index,
// held until released by the holder or force-revoked after MAX_HOLD cycles.
//   IDLE  | no grant; pick next winner from req starting at ptr
//   GRANT | gnt_id owns the resource; hold_cnt counts cycles held minus one
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0] pick;
    logic [1:0] idx;
    logic       hold_expired;

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) pick = idx;
        end
    end

    assign hold_expired = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d    = GRANT;
                    gnt_id_d   = pick;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (done || !req[gnt_id_q] || hold_expired) begin
                    state_d   = IDLE;
                    ptr_d     = gnt_id_q + 2'd1;
                    timeout_d = !done && req[gnt_id_q] && hold_expired;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_id_q   <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy    = (state_q == GRANT);
    assign gnt_id  = gnt_id_q;
    assign gnt     = busy ? (4'b0001 << gnt_id_q) : 4'b0000;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vector table, hand-written timeout/reset
// sequences, and randomized traffic checked against a cycle-level reference model.
module tb_rr_arbiter4;

    localparam int MH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_busy, m_id, m_ptr, m_held, m_to;

    rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {gnt, gnt_id, busy, timeout};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, expected gnt=%b id=%0d busy=%b to=%b",
                     name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    // One clock of the arbitration rules, using the inputs present at the edge.
    task automatic model_edge(input logic [3:0] r, input logic d);
        bit found;
        if (m_busy == 0) begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found  = 1;
                    m_id   = (m_ptr + k) % 4;
                    m_busy = 1;
                    m_held = 1;
                end
            end
        end else if (d || !r[m_id] || m_held == MH) begin
            m_to   = (!d && r[m_id] && m_held == MH) ? 1 : 0;
            m_busy = 0;
            m_ptr  = (m_id + 1) % 4;
        end else begin
            m_held++;
            m_to = 0;
        end
    endtask

    function automatic logic [7:0] model_exp();
        logic [3:0] g;
        g = (m_busy != 0) ? 4'(1 << m_id) : 4'b0000;
        return {g, 2'(m_id), m_busy[0], m_to[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(req, done);
        #1;
    endtask

    initial begin
        // single grant / release
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        // all requesting, done on each first grant cycle (ptr now 1)
        vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        // 1010 pattern: 1 then 3, never 1 twice
        vecs[10] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[13] = '{4'b1010, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        // done while idle is ignored
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[16] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};

        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'b0000_00_0_0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check($sformatf("vec[%0d]", i),
                  {vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to});
        end

        // forced release after MAX_HOLD cycles, sole requester regranted
        req  = 4'b0100;
        done = 1'b0;
        for (int i = 0; i < MH; i++) begin
            step();
            check($sformatf("hold[%0d]", i), 8'b0100_10_1_0);
        end
        step();
        check("timeout_pulse", 8'b0000_10_0_1);
        step();
        check("regrant", 8'b0100_10_1_0);
        req = 4'b0000;
        step();
        check("drop_after_regrant", 8'b0000_10_0_0);

        // done on the last allowed cycle wins over the timeout
        req = 4'b0100;
        for (int i = 0; i < MH; i++) step();
        check("last_cycle_held", 8'b0100_10_1_0);
        done = 1'b1;
        step();
        check("done_at_limit", 8'b0000_10_0_0);
        done = 1'b0;
        req  = 4'b0000;
        step();

        // asynchronous reset while requester 3 holds
        req = 4'b1000;
        step();
        check("pre_reset_grant", 8'b1000_11_1_0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset", 8'b0000_00_0_0);
        req = 4'b1111;
        @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        check("post_reset_grant", 8'b0001_00_1_0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) req = 4'($urandom());
            done = ($urandom_range(9, 0) == 0);
            step();
            check($sformatf("rand[%0d]", i), model_exp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
